// File: rtl/conv_pkg.sv
// Shared constants, writer state encoding and the saturation width rule
// used by the 3x3 convolution engine, its line buffer and the result writer.
package conv_pkg;

    localparam int IN_W   = 19;
    localparam int OUT_W  = 16;
    localparam int COLS   = 510;
    localparam int ROWS   = 510;
    localparam int ADDR_W = 18;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } wr_state_t;

    // Width needed to compare a shifted result against the largest pixel value
    // without truncating either operand.
    function automatic int sat_width(input int in_w, input int out_w);
        return (in_w > out_w) ? in_w : out_w;
    endfunction

endpackage

// File: rtl/conv_result_writer_if.sv
// Ready/valid write port into the output frame memory.
// The writer drives the request side (master), the memory answers with ready (slave).
interface conv_result_writer_if #(
    parameter int ADDR_W = conv_pkg::ADDR_W,
    parameter int OUT_W  = conv_pkg::OUT_W
);
    import conv_pkg::*;

    logic              mem_wen;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [OUT_W-1:0]  mem_wdata;

    modport master (
        output mem_wen,
        output mem_addr,
        output mem_wdata,
        input  mem_ready
    );

    modport slave (
        input  mem_wen,
        input  mem_addr,
        input  mem_wdata,
        output mem_ready
    );

endinterface

// File: rtl/conv_wr_fifo.sv
// Small synchronous FIFO buffering {address, pixel} entries for the result writer.
// The head entry is read straight from the storage registers, so a push is visible
// at dout one cycle later and there is no combinational path from din to dout.
module conv_wr_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    import conv_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // A push into a full FIFO only lands when the head leaves in the same cycle.
    assign w_do_push = push && (!full || pop);
    assign w_do_pop  = pop && !empty;

    // Storage: entries are written at the tail; reset clears them so outputs start at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign full  = (r_count == (PTR_W+1)'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;

endmodule

// File: rtl/conv_result_writer.sv
// Result writer behind the 3x3 convolution engine: shifts and saturates each
// result to pixel width, buffers it with its frame address, writes it out over
// a ready/valid port and reports end of frame, pixel-count errors and drops.
module conv_result_writer #(
    parameter int IN_W       = conv_pkg::IN_W,
    parameter int OUT_W      = conv_pkg::OUT_W,
    parameter int SHIFT      = 0,
    parameter int COLS       = conv_pkg::COLS,
    parameter int ROWS       = conv_pkg::ROWS,
    parameter int ADDR_W     = conv_pkg::ADDR_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [IN_W-1:0]          in_data,
    input  logic                     in_done,
    conv_result_writer_if.master     mem,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     cnt_err,
    output logic                     ovf
);
    import conv_pkg::*;

    localparam int TOTAL   = COLS * ROWS;
    localparam int CNT_W   = $clog2(TOTAL + 1);
    localparam int SAT_W   = sat_width(IN_W, OUT_W);
    localparam int ENTRY_W = ADDR_W + OUT_W;
    localparam int LVL_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [SAT_W-1:0] PIX_MAX = SAT_W'({OUT_W{1'b1}});

    wr_state_t          r_state;
    wr_state_t          w_state_next;
    logic [CNT_W-1:0]   r_pix_cnt;
    logic [CNT_W-1:0]   w_pix_cnt_inc;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic               r_cnt_err;
    logic               r_ovf;

    logic [IN_W-1:0]    w_shifted;
    logic [SAT_W-1:0]   w_shifted_ext;
    logic [OUT_W-1:0]   w_sat;

    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic               w_drop;
    logic               w_reject;
    logic               w_last_pix;
    logic               w_drained;
    logic               w_full;
    logic               w_empty;
    logic [LVL_W-1:0]   w_level;
    logic [ENTRY_W-1:0] w_din;
    logic [ENTRY_W-1:0] w_dout;

    // Truncating shift, then clamp anything above the largest pixel value.
    assign w_shifted     = in_data >> SHIFT;
    assign w_shifted_ext = SAT_W'(w_shifted);
    assign w_sat         = (w_shifted_ext > PIX_MAX) ? {OUT_W{1'b1}} : w_shifted_ext[OUT_W-1:0];

    // Pixels are taken only while a frame can still grow; a full FIFO without a
    // simultaneous pop loses the pixel but the counters still advance so the
    // addresses of later pixels stay at their true frame positions.
    assign w_accept      = in_valid && ((r_state == IDLE) || (r_state == RUN));
    assign w_pop         = !w_empty && mem.mem_ready;
    assign w_push        = w_accept && (!w_full || w_pop);
    assign w_drop        = w_accept && w_full && !w_pop;
    assign w_reject      = in_valid && !w_accept;
    assign w_pix_cnt_inc = r_pix_cnt + CNT_W'(1);
    assign w_last_pix    = w_accept && (w_pix_cnt_inc == CNT_W'(TOTAL));
    assign w_drained     = w_empty || ((w_level == LVL_W'(1)) && w_pop);
    assign w_din         = {r_wr_addr, w_sat};

    conv_wr_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_din),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty),
        .count (w_level)
    );

    // Writer state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: a pixel arriving with in_done is accepted before the frame closes,
    // and DRAIN exits once the last queued entry is leaving the FIFO.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_state_next = (in_done || w_last_pix) ? DRAIN : RUN;
                end else if (in_done) begin
                    w_state_next = DONE;
                end
            end
            RUN: begin
                if (in_done || w_last_pix) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (w_drained) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Pixel counter and write address advance together and restart after each frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pix_cnt <= '0;
            r_wr_addr <= '0;
        end else if (r_state == DONE) begin
            r_pix_cnt <= '0;
            r_wr_addr <= '0;
        end else if (w_accept) begin
            r_pix_cnt <= w_pix_cnt_inc;
            r_wr_addr <= r_wr_addr + ADDR_W'(1);
        end
    end

    // Sticky error flags; cnt_err is judged on entry to DONE so it is valid with frame_done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt_err <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            if ((r_state != DONE) && (w_state_next == DONE) && (r_pix_cnt != CNT_W'(TOTAL))) begin
                r_cnt_err <= 1'b1;
            end
            if (w_drop || w_reject) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign mem.mem_wen   = !w_empty;
    assign mem.mem_addr  = w_dout[ENTRY_W-1:OUT_W];
    assign mem.mem_wdata = w_dout[OUT_W-1:0];
    assign busy          = (r_state == RUN) || (r_state == DRAIN);
    assign frame_done    = (r_state == DONE);
    assign cnt_err       = r_cnt_err;
    assign ovf           = r_ovf;

endmodule

// File: doc/conv_result_writer.md
Name: conv_result_writer

Overview:
- Downstream stage of the 3x3 line-buffer convolution engine. Consumes its result stream (19-bit result, o_en strobe, done pulse).
- Shifts and saturates each result to pixel width, then buffers it in a small FIFO.
- Writes pixels sequentially into an output frame memory through a ready/valid write port.
- Pulses frame_done once the frame is fully drained; reports pixel-count mismatch and overflow.

Parameters:
- IN_W, 19, width of incoming convolution result
- OUT_W, 16, width of written pixel
- SHIFT, 0, right-shift applied to result before saturation
- COLS, 510, valid output pixels per row
- ROWS, 510, valid output rows per frame
- ADDR_W, 18, output memory address width (must hold COLS*ROWS-1)
- FIFO_DEPTH, 4, write buffer depth (power of two)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  result strobe (driven by conv o_en)
- in_data  in  IN_W  convolution result
- in_done  in  1  end-of-frame pulse from conv engine
- mem_wen  out  1  write request, valid while FIFO non-empty
- mem_ready  in  1  memory accepts write this cycle
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  OUT_W  write data
- busy  out  1  high in RUN or DRAIN
- frame_done  out  1  one-cycle pulse when frame fully written
- cnt_err  out  1  sticky: frame ended with pixel count != COLS*ROWS
- ovf  out  1  sticky: result dropped (FIFO full or not accepting)

Behaviour:
- Reset (rst=0, async): all outputs 0, state IDLE, FIFO empty, pix_cnt=0, wr_addr=0. Sticky flags are cleared only by reset.
- Data path: d = in_data >> SHIFT. wdata = (d > 2^OUT_W-1) ? 2^OUT_W-1 : d[OUT_W-1:0]. No rounding.
- Address: wr_addr is a counter, +1 per accepted pixel, stored in the FIFO alongside the data. Pixel k lands at address k (row-major, row = k/COLS).
- States:
  - IDLE: in_valid -> RUN, and this pixel is accepted. in_done alone -> DONE (cnt_err set since count 0).
  - RUN: accept each in_valid. Go to DRAIN on in_done, or when the accepted pixel makes pix_cnt == COLS*ROWS (whichever comes first; both in the same cycle is one transition).
  - DRAIN: in_valid ignored and sets ovf. Go to DONE when FIFO is empty and no pop is in flight.
  - DONE: frame_done=1 for exactly one cycle. cnt_err |= (pix_cnt != COLS*ROWS). Clear pix_cnt and wr_addr. Go to IDLE.
- FIFO:
  - push = accepted in_valid. pop = mem_wen & mem_ready.
  - mem_wen/mem_addr/mem_wdata come from the FIFO head, which is registered. Minimum latency from in_valid at cycle N is mem_wen at N+1.
  - mem_addr/mem_wdata must hold stable while mem_wen=1 and mem_ready=0.
  - Full with push and simultaneous pop: push accepted. Full with push and no pop: pixel dropped, ovf=1, pix_cnt and wr_addr still advance so later addresses stay correct.
  - Empty: mem_wen=0. A push into an empty FIFO appears next cycle; there is no combinational bypass.
- in_valid and in_done in the same cycle: the pixel is accepted first, then the transition is taken.
- in_done while IDLE after a completed frame: goes to DONE, frame_done pulses, cnt_err set.
- busy = (state==RUN || state==DRAIN).
- Reset asserted mid-frame: FIFO contents discarded, no write in flight completes, mem_wen=0 immediately.

Decomposition:
- Shared package conv_pkg holds:
  - IN_W, OUT_W, COLS, ROWS, ADDR_W constants, shared with the conv engine and line buffer.
  - The writer state encoding: IDLE=2'd0, RUN=2'd1, DRAIN=2'd2, DONE=2'd3.
  - The saturate-function width rule.
- One natural sub-module: conv_wr_fifo. It is a synchronous FIFO with parameterised width and depth, ports push/pop/din/dout/full/empty, and async active-low reset. The top level holds the FSM, counters, saturation and sticky flags.

Test Plan:
- Single pixel: rst release, in_valid with in_data=19'd1000, mem_ready=1 -> next cycle mem_wen=1, mem_addr=0, mem_wdata=16'd1000. in_done -> frame_done pulse, cnt_err=1.
- Saturation: in_data=19'h7FFFF, SHIFT=0 -> mem_wdata=16'hFFFF. in_data=19'h0FFFF -> 16'hFFFF. With SHIFT=2, in_data=19'd400 -> 16'd100.
- Full frame (COLS=ROWS=4 override): 16 strobes spaced 12 cycles, mem_ready=1 -> addresses 0..15 in order. frame_done one cycle after last write. cnt_err=0, ovf=0.
- Backpressure: mem_ready=0 for 10 cycles while 6 back-to-back strobes arrive -> first 4 buffered, 2 dropped, ovf=1. On release, addresses 0,1,2,3 written; next accepted pixel uses address 6.
- Early done: in_done after 10 of 16 pixels -> DRAIN empties the FIFO, frame_done pulses, cnt_err=1. A later in_valid during DRAIN sets ovf.
- Async reset mid-DRAIN with 3 entries queued -> mem_wen=0, busy=0 immediately. Next frame restarts at mem_addr=0.
